// File: rtl/uart_tx_sequencer_if.sv
// AXI-stream byte channel feeding the UART transmit sequencer.
interface uart_tx_sequencer_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;

  modport master (output s_axis_tdata, output s_axis_tvalid, input s_axis_tready);
  modport slave  (input s_axis_tdata, input s_axis_tvalid, output s_axis_tready);
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART frame sequencer: start bit, LSB-first data, stop bit(s), paced by an
// oversampled baud strobe. All outputs are registered.
module uart_tx_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 baud_tick_i,
  uart_tx_sequencer_if.slave   s_axis,
  output logic                 tx_o,
  output logic                 busy_o
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bitc_q, bitc_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tready_q, tready_d;

  logic accept, bit_end;

  // ready is only ever set in IDLE, so this is the handshake
  assign accept  = s_axis.s_axis_tvalid & tready_q;
  // ticks are ignored in IDLE, which also drops a tick in the accept cycle
  assign bit_end = (state_q != IDLE) && baud_tick_i && (cnt_q == CNT_MAX);

  assign s_axis.s_axis_tready = tready_q;
  assign tx_o   = tx_q;
  assign busy_o = busy_q;

  // next-state: tx/busy/ready are computed alongside the state so they
  // switch on the same edge as the state register
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitc_d   = bitc_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    tready_d = tready_q;

    if (state_q != IDLE && baud_tick_i)
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        tready_d = 1'b1;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        if (accept) begin
          sh_d     = s_axis.s_axis_tdata[DATA_BITS-1:0];
          cnt_d    = '0;
          bitc_d   = '0;
          state_d  = START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          tready_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bitc_d  = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bitc_q == DATA_LAST) begin
            state_d = STOP;
            bitc_d  = '0;
            tx_d    = 1'b1;
          end else begin
            bitc_d = bitc_q + 3'd1;
            tx_d   = sh_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bitc_q == STOP_LAST) begin
            state_d  = IDLE;
            bitc_d   = '0;
            tx_d     = 1'b1;
            busy_d   = 1'b0;
            tready_d = 1'b1;
          end else begin
            bitc_d = bitc_q + 3'd1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b0;
      end
    endcase
  end

  // state registers; reset aborts any frame and holds ready low until release
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitc_q   <= '0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitc_q   <= bitc_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      tready_q <= tready_d;
    end
  end
endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 Parameter OVERSAMPLE, default 16: baud ticks per serial bit; legal range 2..256.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n_i  input  1  reset, synchronous, active-low.
REQ-006 baud_tick_i  input  1  oversample strobe from the NCO baud generator; one-cycle pulse, or tied high for one tick per clock.
REQ-007 s_axis_tdata  input  8  byte to transmit; bits above DATA_BITS-1 are ignored.
REQ-008 s_axis_tvalid  input  1  AXI-stream valid.
REQ-009 s_axis_tready  output  1  AXI-stream ready.
REQ-010 tx_o  output  1  serial line, idle high.
REQ-011 busy_o  output  1  high while a frame is in progress.

Function
REQ-012 State machine SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-013 s_axis_tready SHALL be high only in IDLE, registered, with no combinational path from s_axis_tvalid.
REQ-014 Accept occurs when s_axis_tvalid and s_axis_tready are high in the same cycle; on accept, SHALL latch tdata into a shift register, clear the tick counter and bit counter, and enter START next cycle.
REQ-015 tx_o SHALL be registered and SHALL equal 1 in IDLE, 0 in START, the current shift-register LSB in DATA, and 1 in STOP.
REQ-016 tx_o SHALL change in the same cycle the state changes, with no extra pipeline stage.
REQ-017 Tick counter width SHALL be clog2(OVERSAMPLE); it counts baud_tick_i pulses only outside IDLE.
REQ-018 A baud_tick_i in the accept cycle SHALL NOT be counted.
REQ-019 Bit-period end is a cycle with baud_tick_i=1 and tick counter = OVERSAMPLE-1.
   - At bit-period end the counter wraps to 0.
   - The state or bit advances on the next clock edge.
REQ-020 START SHALL last one bit period, then go to DATA with bit counter = 0.
REQ-021 In DATA, each bit-period end SHALL shift the register right by one (LSB first) and increment the bit counter.
REQ-022 After bit DATA_BITS-1, DATA SHALL go to STOP.
REQ-023 STOP SHALL last STOP_BITS bit periods, then return to IDLE; s_axis_tready rises on that same edge.
REQ-024 busy_o SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-025 s_axis_tvalid and s_axis_tdata changes outside IDLE SHALL have no effect on tx_o or the latched byte.
REQ-026 If baud_tick_i is tied high, each bit SHALL last exactly OVERSAMPLE clocks, and a frame exactly (1+DATA_BITS+STOP_BITS)*OVERSAMPLE clocks from the cycle after accept.
REQ-027 Minimum gap between consecutive accepts SHALL be frame length + 1 clock (one IDLE cycle).

Reset
REQ-028 While rst_n_i=0 at a clock edge, the next state SHALL be:
   - state IDLE, tx_o=1, busy_o=0
   - s_axis_tready=0, all counters and the shift register 0.
REQ-029 s_axis_tready SHALL rise on the first clock edge with rst_n_i=1.
REQ-030 Reset during any state SHALL abort the frame, with tx_o=1 from the next edge, and the byte SHALL NOT be resumed or re-sent.

Verification (defaults; tick every 4 clocks unless stated)
REQ-031 Accept 0xA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each level 64 clocks (16 ticks); busy_o high 640 clocks; then tready high.
REQ-032 baud_tick_i tied high, accept 0x00 then hold tvalid with 0xFF -> first frame 160 clocks, exactly 1 IDLE cycle, then second frame starts; 2 accepts total.
REQ-033 Toggle tvalid and tdata throughout an 0x3C frame -> output matches 0x3C exactly; no accept until IDLE.
REQ-034 Assert rst_n_i low for 1 clock during DATA bit 3 -> tx_o=1 and busy_o=0 next edge; tready=1 one edge after release; no further bits emitted.
REQ-035 baud_tick_i pulse in the accept cycle -> start bit ends on the 16th subsequent tick, not the 15th.
REQ-036 DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=4, tick tied high, accept 0xFF -> tx_o low 4 clocks, high 36 clocks; bit 7 of tdata ignored.
